// File: rtl/interconnect_link_boundary_buffer.sv
// Per-plane FIFO buffer for one direction of an interconnect link.
// Breaks the req/ack combinational path and reports when every plane is empty.
module interconnect_link_boundary_buffer #(
    parameter int NUM_PLANES = 2,
    parameter int TAG_WIDTH  = 3,
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      enable,
    input  logic [NUM_PLANES*TAG_WIDTH-1:0]           input_tag_lines,
    input  logic [NUM_PLANES*WORD_WIDTH-1:0]          input_data_lines,
    input  logic [NUM_PLANES-1:0]                     input_reqs,
    output logic [NUM_PLANES-1:0]                     input_acks,
    output logic [NUM_PLANES*TAG_WIDTH-1:0]           output_tag_lines,
    output logic [NUM_PLANES*WORD_WIDTH-1:0]          output_data_lines,
    output logic [NUM_PLANES-1:0]                     output_reqs,
    input  logic [NUM_PLANES-1:0]                     output_acks,
    output logic [NUM_PLANES*$clog2(DEPTH+1)-1:0]     occupancies,
    output logic                                      quiescent
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = TAG_WIDTH + WORD_WIDTH;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    logic [NUM_PLANES-1:0] plane_empty;

    assign quiescent = &plane_empty;

    for (genvar p = 0; p < NUM_PLANES; p++) begin : g_plane
        logic [ENTRY_W-1:0] mem_q [DEPTH];
        logic [ENTRY_W-1:0] mem_d [DEPTH];
        logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
        logic [CNT_W-1:0]   count_q, count_d;
        logic               ack, req, push, pop;
        logic [ENTRY_W-1:0] head;

        // Handshake outputs come from registered count only, never from the far side.
        assign ack  = enable & (count_q != CNT_W'(DEPTH));
        assign req  = enable & (count_q != '0);
        assign push = input_reqs[p] & ack;
        assign pop  = output_acks[p] & req;
        assign head = mem_q[rd_ptr_q];

        assign input_acks[p]                                  = ack;
        assign output_reqs[p]                                 = req;
        assign output_tag_lines[TAG_WIDTH*p +: TAG_WIDTH]     = head[ENTRY_W-1 -: TAG_WIDTH];
        assign output_data_lines[WORD_WIDTH*p +: WORD_WIDTH]  = head[WORD_WIDTH-1:0];
        assign occupancies[CNT_W*p +: CNT_W]                  = count_q;
        assign plane_empty[p]                                 = (count_q == '0);

        always_comb begin
            mem_d    = mem_q;
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;
            if (push) begin
                mem_d[wr_ptr_q] = {input_tag_lines[TAG_WIDTH*p +: TAG_WIDTH],
                                   input_data_lines[WORD_WIDTH*p +: WORD_WIDTH]};
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end

        // Storage is cleared on reset so the head reads zero after reset.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[i] <= '0;
                end
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[i] <= mem_d[i];
                end
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
            end
        end
    end

endmodule
